// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants and next-state action selection for fetch_stage
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam int          OPCODE_MSB       = 31;
    localparam int          OPCODE_LSB       = 26;
    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ACT_FETCH  = 2'd0,
        ACT_STALL  = 2'd1,
        ACT_JUMP   = 2'd2,
        ACT_BRANCH = 2'd3
    } fetch_act_e;

    // Stall masks any redirect; the hazard unit re-issues it once the stall clears.
    function automatic fetch_act_e sel_action(input logic stall, input logic jump,
                                              input logic branch_taken);
        if (stall)             return ACT_STALL;
        else if (jump)         return ACT_JUMP;
        else if (branch_taken) return ACT_BRANCH;
        else                   return ACT_FETCH;
    endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// rtl/fetch_perf_counters.sv - saturating fetch/stall/flush event counters
module fetch_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] fetched_o,
    output logic [CNT_W-1:0] stalls_o,
    output logic [CNT_W-1:0] flushes_o
);

    logic [CNT_W-1:0] fetched_q, stalls_q, flushes_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= '0;
            stalls_q  <= '0;
            flushes_q <= '0;
        end else begin
            if (fetch_i && fetched_q != '1) fetched_q <= fetched_q + 1'b1;
            if (stall_i && stalls_q  != '1) stalls_q  <= stalls_q  + 1'b1;
            if (flush_i && flushes_q != '1) flushes_q <= flushes_q + 1'b1;
        end
    end

    assign fetched_o = fetched_q;
    assign stalls_o  = stalls_q;
    assign flushes_o = flushes_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS IF stage: PC, IF/ID register, stall/redirect; FETCH_PERF_CNT_EN adds counters
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
`ifdef FETCH_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] if_id_instr,
    output logic [5:0]  if_id_opcode,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [31:0] pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_fetched,
    output logic [CNT_W-1:0] perf_stalls,
    output logic [CNT_W-1:0] perf_flushes
`endif
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_plus4;
    fetch_act_e  act;

    // Targets are word aligned, so their low bits are intentionally dropped.
    logic unused_tgt_bits;
    assign unused_tgt_bits = ^{branch_target[1:0], jump_target[1:0]};

    assign pc_plus4 = pc_q + PC_INCR;
    assign act      = sel_action(stall, jump, branch_taken);

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        case (act)
            ACT_STALL: ;
            ACT_JUMP: begin
                pc_d    = {jump_target[31:2], 2'b00};
                instr_d = NOP_INSTR;
                pc4_d   = '0;
                valid_d = 1'b0;
            end
            ACT_BRANCH: begin
                pc_d    = {branch_target[31:2], 2'b00};
                instr_d = NOP_INSTR;
                pc4_d   = '0;
                valid_d = 1'b0;
            end
            default: begin
                pc_d    = pc_plus4;
                instr_d = imem_rdata;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign if_id_instr  = instr_q;
    assign if_id_opcode = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign if_id_pc4    = pc4_q;
    assign if_id_valid  = valid_q;

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_counters #(.CNT_W(CNT_W)) u_perf (
        .clk       (clk),
        .rst_n     (rst_n),
        .fetch_i   (act == ACT_FETCH),
        .stall_i   (act == ACT_STALL),
        .flush_i   (act == ACT_JUMP || act == ACT_BRANCH),
        .fetched_o (perf_fetched),
        .stalls_o  (perf_stalls),
        .flushes_o (perf_flushes)
    );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr, imem_rdata;
    logic        stall, branch_taken, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] if_id_instr, if_id_pc4, pc;
    logic [5:0]  if_id_opcode;
    logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stalls, perf_flushes;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Instruction memory: two fixed words, otherwise an address-derived pattern.
    always_comb begin
        case (imem_addr)
            32'h0000_0000: imem_rdata = 32'h2008_0005;
            32'h0000_0004: imem_rdata = 32'h8D09_0004;
            default:       imem_rdata = 32'hC000_0000 ^ imem_addr;
        endcase
    end

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .if_id_instr   (if_id_instr),
        .if_id_opcode  (if_id_opcode),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .pc            (pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_stalls   (perf_stalls),
        .perf_flushes  (perf_flushes)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 0; branch_taken = 0; jump = 0;
        branch_target = 0; jump_target = 0;
        #2;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
        checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", if_id_instr); end
        checks++; if (if_id_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h want 0", if_id_pc4); end
        step(); step();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_hold_pc: got %h want 0", pc); end
        rst_n = 1'b1;
    endtask

    task automatic test_straight_line();
        step();
        checks++; if (if_id_instr !== 32'h2008_0005) begin errors++; $display("FAIL line1_instr: got %h want 20080005", if_id_instr); end
        checks++; if (if_id_opcode !== 6'b001000) begin errors++; $display("FAIL line1_opcode: got %b want 001000", if_id_opcode); end
        checks++; if (if_id_pc4 !== 32'h4) begin errors++; $display("FAIL line1_pc4: got %h want 4", if_id_pc4); end
        checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL line1_valid: got %b want 1", if_id_valid); end
        step();
        checks++; if (if_id_instr !== 32'h8D09_0004) begin errors++; $display("FAIL line2_instr: got %h want 8d090004", if_id_instr); end
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL line2_pc: got %h want 8", pc); end
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL line2_imem_addr: got %h want 8", imem_addr); end
    endtask

    task automatic test_stall();
        step(); step();
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stall_setup_pc: got %h want 10", pc); end
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stall_pc[%0d]: got %h want 10", i, pc); end
            checks++; if (if_id_instr !== 32'hC000_000C || if_id_pc4 !== 32'h10 || if_id_valid !== 1'b1) begin
                errors++; $display("FAIL stall_ifid[%0d]: got %h/%h/%b want c000000c/10/1", i, if_id_instr, if_id_pc4, if_id_valid);
            end
        end
        stall = 1'b0;
        step();
        checks++; if (pc !== 32'h14) begin errors++; $display("FAIL stall_resume_pc: got %h want 14", pc); end
        checks++; if (if_id_instr !== 32'hC000_0010 || if_id_pc4 !== 32'h14) begin
            errors++; $display("FAIL stall_resume_ifid: got %h/%h want c0000010/14", if_id_instr, if_id_pc4);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (perf_stalls !== 32'd2) begin errors++; $display("FAIL perf_stalls: got %0d want 2", perf_stalls); end
        checks++; if (perf_fetched !== 32'd5) begin errors++; $display("FAIL perf_fetched: got %0d want 5", perf_fetched); end
`endif
    endtask

    task automatic test_branch();
        step(); step(); step();
        checks++; if (pc !== 32'h20) begin errors++; $display("FAIL branch_setup_pc: got %h want 20", pc); end
        branch_taken = 1'b1; branch_target = 32'h0000_0043;
        step();
        branch_taken = 1'b0;
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL branch_pc: got %h want 40", pc); end
        checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_opcode !== 6'h0) begin
            errors++; $display("FAIL branch_flush: got %b/%h/%b want 0/0/000000", if_id_valid, if_id_instr, if_id_opcode);
        end
        step();
        checks++; if (if_id_pc4 !== 32'h44 || if_id_valid !== 1'b1 || if_id_instr !== 32'hC000_0040) begin
            errors++; $display("FAIL branch_target_fetch: got %h/%b/%h want 44/1/c0000040", if_id_pc4, if_id_valid, if_id_instr);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (perf_flushes !== 32'd1) begin errors++; $display("FAIL perf_flushes: got %0d want 1", perf_flushes); end
`endif
    endtask

    task automatic test_jump_branch();
        jump = 1'b1; jump_target = 32'h100; branch_taken = 1'b1; branch_target = 32'h200;
        step();
        jump = 1'b0; branch_taken = 1'b0;
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL jump_wins_pc: got %h want 100", pc); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL jump_flush_valid: got %b want 0", if_id_valid); end
        step();
        checks++; if (pc !== 32'h104 || if_id_instr !== 32'hC000_0100) begin
            errors++; $display("FAIL jump_target_fetch: got %h/%h want 104/c0000100", pc, if_id_instr);
        end
    endtask

    task automatic test_stall_jump();
        jump = 1'b1; jump_target = 32'h2C;
        step();
        jump = 1'b0;
        step();
        checks++; if (pc !== 32'h30) begin errors++; $display("FAIL stall_jump_setup_pc: got %h want 30", pc); end
        stall = 1'b1; jump = 1'b1; jump_target = 32'h80;
        step();
        checks++; if (pc !== 32'h30) begin errors++; $display("FAIL stall_jump_pc: got %h want 30", pc); end
        checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'hC000_002C || if_id_pc4 !== 32'h30) begin
            errors++; $display("FAIL stall_jump_noflush: got %b/%h/%h want 1/c000002c/30", if_id_valid, if_id_instr, if_id_pc4);
        end
        stall = 1'b0; jump = 1'b0;
        step();
        checks++; if (pc !== 32'h34) begin errors++; $display("FAIL stall_jump_resume_pc: got %h want 34", pc); end
    endtask

    task automatic test_async_reset();
        step(); step();
        checks++; if (pc !== 32'h3C || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL areset_setup: got %h/%b want 3c/1", pc, if_id_valid);
        end
        #2;
        rst_n = 1'b0;
        jump = 1'b1; jump_target = 32'h400;
        #1;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL areset_pc: got %h want 0", pc); end
        checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
            errors++; $display("FAIL areset_ifid: got %b/%h want 0/0", if_id_valid, if_id_instr);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (perf_fetched !== 0 || perf_stalls !== 0 || perf_flushes !== 0) begin
            errors++; $display("FAIL areset_perf: got %0d/%0d/%0d want 0/0/0", perf_fetched, perf_stalls, perf_flushes);
        end
`endif
        step();
        jump = 1'b0;
        rst_n = 1'b1;
        step();
        checks++; if (if_id_instr !== 32'h2008_0005 || if_id_pc4 !== 32'h4 || pc !== 32'h4) begin
            errors++; $display("FAIL areset_first_fetch: got %h/%h/%h want 20080005/4/4", if_id_instr, if_id_pc4, pc);
        end
    endtask

    task automatic test_wrap();
        jump = 1'b1; jump_target = 32'hFFFF_FFFF;
        step();
        jump = 1'b0;
        checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_align_pc: got %h want fffffffc", pc); end
        step();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want 0", pc); end
        checks++; if (if_id_pc4 !== 32'h0 || if_id_valid !== 1'b1 || if_id_instr !== 32'h3FFF_FFFC) begin
            errors++; $display("FAIL wrap_ifid: got %h/%b/%h want 0/1/3ffffffc", if_id_pc4, if_id_valid, if_id_instr);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_straight_line();
        test_stall();
        test_branch();
        test_jump_branch();
        test_stall_jump();
        test_async_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
